rc5_cbc_ctrl: RTL and testbench

RC5_CBC_CTRL -- requirements
Module: rc5_cbc_ctrl

---
 rtl/rc5_pkg.sv | 5 +
 rtl/rc5_cbc_ctrl.sv | 127 ++++++++++++
 tb/tb_rc5_cbc_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rc5_pkg.sv
// rc5_pkg: shared FSM state encoding and block width for the RC5 CBC controller.
package rc5_pkg;
    localparam int BLOCK_W = 32;
    typedef enum logic [2:0] {IDLE, KEYLOAD, READY, ISSUE, WAIT, OUT} state_t;
endpackage

// File: rtl/rc5_cbc_ctrl.sv
// rc5_cbc_ctrl: CBC chaining, key-load sequencing and stream handshake around an RC5 core.
// One block in flight; core handshakes are bounded by a saturating timeout counter.
module rc5_cbc_ctrl
    import rc5_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [127:0]       cfg_key,
    input  logic [4:0]         cfg_rounds,
    input  logic [BLOCK_W-1:0] cfg_iv,
    input  logic               cfg_decrypt,
    input  logic               cfg_load,
    output logic               cfg_busy,
    output logic               err,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BLOCK_W-1:0] s_data,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BLOCK_W-1:0] m_data,
    output logic               m_last,
    output logic [4:0]         core_num_rounds,
    output logic [127:0]       core_key,
    output logic               core_load_key,
    input  logic               core_key_ready,
    output logic               core_start_encrypt,
    output logic               core_start_decrypt,
    output logic [BLOCK_W-1:0] core_d_in,
    input  logic [BLOCK_W-1:0] core_d_out,
    input  logic               core_done
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [127:0]       r_key;
    logic [4:0]         r_rounds;
    logic [BLOCK_W-1:0] r_iv, r_chain, r_ct_hold, r_d_in, r_m_data;
    logic               r_decrypt, r_last, r_m_last, r_err;
    logic               w_load, w_accept, w_to, w_kr, w_err;

    assign w_load   = cfg_load && (r_state == IDLE || r_state == READY);
    assign w_kr     = core_key_ready && r_cnt != '0;
    assign w_to     = r_cnt == CW'(TIMEOUT - 1);
    // A same-cycle cfg_load wins over a new block, so the block is not handshaken
    assign s_ready  = r_state == READY && !cfg_load;
    assign w_accept = s_valid && s_ready;
    assign w_err    = (r_state == KEYLOAD && !w_kr && w_to) ||
                      (r_state == WAIT && !core_done && w_to);

    assign cfg_busy           = r_state != IDLE && r_state != READY;
    assign m_valid            = r_state == OUT;
    assign core_load_key      = r_state == KEYLOAD && r_cnt == '0;
    assign core_start_encrypt = r_state == ISSUE && !r_decrypt;
    assign core_start_decrypt = r_state == ISSUE && r_decrypt;
    assign core_key           = r_key;
    assign core_num_rounds    = r_rounds;
    assign core_d_in          = r_d_in;
    assign m_data             = r_m_data;
    assign m_last             = r_m_last;
    assign err                = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_load ? KEYLOAD : IDLE;
            KEYLOAD: w_next = w_kr ? READY : w_to ? IDLE : KEYLOAD;
            READY:   w_next = w_load ? KEYLOAD : w_accept ? ISSUE : READY;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = core_done ? OUT : w_to ? READY : WAIT;
            OUT:     w_next = m_ready ? READY : OUT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cnt <= '0;
        else if (w_next != r_state) r_cnt <= '0;
        else if ((r_state == KEYLOAD || r_state == WAIT) && r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key     <= '0;
            r_rounds  <= '0;
            r_iv      <= '0;
            r_decrypt <= 1'b0;
            r_chain   <= '0;
            r_ct_hold <= '0;
            r_d_in    <= '0;
            r_m_data  <= '0;
            r_last    <= 1'b0;
            r_m_last  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_load) begin
                r_key     <= cfg_key;
                r_rounds  <= cfg_rounds;
                r_iv      <= cfg_iv;
                r_decrypt <= cfg_decrypt;
                r_chain   <= cfg_iv;
                r_err     <= 1'b0;
            end
            if (w_err) r_err <= 1'b1;
            if (w_accept) begin
                r_d_in <= r_decrypt ? s_data : s_data ^ r_chain;
                r_last <= s_last;
                if (r_decrypt) r_ct_hold <= s_data;
            end
            if (r_state == WAIT && core_done) begin
                r_m_data <= r_decrypt ? core_d_out ^ r_chain : core_d_out;
                r_chain  <= r_decrypt ? r_ct_hold : core_d_out;
                r_m_last <= r_last;
            end
            // End of message restarts the chain from the stored IV
            if (r_state == OUT && m_ready && r_m_last) r_chain <= r_iv;
        end
    end
endmodule

// File: tb/tb_rc5_cbc_ctrl.sv
// tb_rc5_cbc_ctrl: directed bench for rc5_cbc_ctrl with an XOR stub core
// (d_out = d_in ^ A5A5A5A5, done 3 cycles after start, key_ready 2 cycles after load).
module tb_rc5_cbc_ctrl;
    logic         clk = 1'b0, reset = 1'b1;
    logic [127:0] cfg_key = 128'h0123456789ABCDEF_FEDCBA9876543210;
    logic [4:0]   cfg_rounds = 5'd12;
    logic [31:0]  cfg_iv = '0;
    logic         cfg_decrypt = 1'b0, cfg_load = 1'b0;
    logic         cfg_busy, err;
    logic         s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [31:0]  s_data = '0;
    logic         m_valid, m_ready = 1'b0, m_last;
    logic [31:0]  m_data;
    logic [4:0]   core_num_rounds;
    logic [127:0] core_key;
    logic         core_load_key, core_key_ready, core_start_encrypt, core_start_decrypt, core_done;
    logic [31:0]  core_d_in, core_d_out;
    int           n_cmp = 0, n_err = 0;

    logic [1:0]  kr_p;
    logic [2:0]  dn_p;
    logic [31:0] hold;
    logic        no_done = 1'b0;

    always #5 clk = ~clk;

    rc5_cbc_ctrl #(.TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .cfg_key(cfg_key), .cfg_rounds(cfg_rounds), .cfg_iv(cfg_iv),
        .cfg_decrypt(cfg_decrypt), .cfg_load(cfg_load), .cfg_busy(cfg_busy), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_num_rounds(core_num_rounds), .core_key(core_key), .core_load_key(core_load_key),
        .core_key_ready(core_key_ready), .core_start_encrypt(core_start_encrypt),
        .core_start_decrypt(core_start_decrypt), .core_d_in(core_d_in), .core_d_out(core_d_out),
        .core_done(core_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kr_p <= '0;
            dn_p <= '0;
            hold <= '0;
        end else begin
            kr_p <= {kr_p[0], core_load_key};
            dn_p <= {dn_p[1:0], (core_start_encrypt | core_start_decrypt) & ~no_done};
            if (core_start_encrypt | core_start_decrypt) hold <= core_d_in;
        end
    end
    assign core_key_ready = kr_p[1];
    assign core_done      = dn_p[2];
    assign core_d_out     = hold ^ 32'hA5A5A5A5;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [31:0] iv, input logic dec);
        cfg_iv = iv;
        cfg_decrypt = dec;
        cfg_load = 1'b1;
        tick;
        cfg_load = 1'b0;
        chk("load_pulse", 32'(core_load_key), 1);
        chk("load_busy", 32'(cfg_busy), 1);
        chk("load_no_ready", 32'(s_ready), 0);
        tick;
        chk("load_pulse_once", 32'(core_load_key), 0);
        for (int i = 0; i < 20 && !s_ready; i++) tick;
        chk("load_ready", 32'(s_ready), 1);
        chk("load_idle_busy", 32'(cfg_busy), 0);
    endtask

    task automatic xfer(input string tag, input logic [31:0] d, input logic last, input logic [31:0] exp);
        s_data = d;
        s_last = last;
        s_valid = 1'b1;
        tick;
        s_valid = 1'b0;
        chk({tag, "_start_enc"}, 32'(core_start_encrypt), 32'(!cfg_decrypt));
        chk({tag, "_start_dec"}, 32'(core_start_decrypt), 32'(cfg_decrypt));
        for (int i = 0; i < 20 && !m_valid; i++) tick;
        chk({tag, "_valid"}, 32'(m_valid), 1);
        chk({tag, "_data"}, m_data, exp);
        chk({tag, "_last"}, 32'(m_last), 32'(last));
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        chk({tag, "_ready_after"}, 32'(s_ready), 1);
    endtask

    initial begin
        logic [31:0] held;
        logic        bad_bp, seen_v, seen_r;
        int          n;
        #12;
        chk("rst_busy", 32'(cfg_busy), 0);
        chk("rst_sready", 32'(s_ready), 0);
        chk("rst_mvalid", 32'(m_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_dinn", core_d_in, 0);
        reset = 1'b0;
        tick;
        tick;
        chk("idle_sready", 32'(s_ready), 0);
        do_load(32'h00000000, 1'b0);
        chk("core_key", 32'(core_key == cfg_key), 1);
        chk("core_rounds", 32'(core_num_rounds), 12);

        do_load(32'h11111111, 1'b0);
        xfer("enc0", 32'h00000000, 1'b0, 32'hB4B4B4B4);
        xfer("enc1", 32'hFFFFFFFF, 1'b0, 32'hEEEEEEEE);

        do_load(32'h11111111, 1'b1);
        xfer("dec0", 32'hB4B4B4B4, 1'b0, 32'h00000000);
        xfer("dec1", 32'hEEEEEEEE, 1'b0, 32'hFFFFFFFF);

        do_load(32'h11111111, 1'b0);
        s_data = 32'h00000000;
        s_last = 1'b1;
        s_valid = 1'b1;
        tick;
        s_valid = 1'b0;
        for (int i = 0; i < 20 && !m_valid; i++) tick;
        held = m_data;
        chk("bp_data", held, 32'hB4B4B4B4);
        bad_bp = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (!m_valid || m_data !== held || s_ready || !m_last) bad_bp = 1'b1;
        end
        s_valid = 1'b0;
        chk("bp_stable", 32'(bad_bp), 0);
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        xfer("bp_rechain", 32'h00000000, 1'b0, 32'hB4B4B4B4);

        no_done = 1'b1;
        s_data = 32'h12345678;
        s_last = 1'b0;
        s_valid = 1'b1;
        tick;
        s_valid = 1'b0;
        n = 0;
        seen_v = 1'b0;
        for (int i = 0; i < 400 && !err; i++) begin
            tick;
            n++;
            if (m_valid) seen_v = 1'b1;
        end
        chk("to_err", 32'(err), 1);
        chk("to_cycles", 32'(n), 256);
        chk("to_no_mvalid", 32'(seen_v), 0);
        chk("to_sready", 32'(s_ready), 1);
        no_done = 1'b0;
        do_load(32'h11111111, 1'b0);
        chk("to_err_clear", 32'(err), 0);

        s_data = 32'h0000FFFF;
        s_valid = 1'b1;
        tick;
        s_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        chk("rr_busy", 32'(cfg_busy), 0);
        chk("rr_mvalid", 32'(m_valid), 0);
        chk("rr_start", 32'(core_start_encrypt | core_start_decrypt | core_load_key), 0);
        chk("rr_din", core_d_in, 0);
        chk("rr_key", 32'(core_key == 128'd0), 1);
        reset = 1'b0;
        seen_v = 1'b0;
        seen_r = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (m_valid || core_start_encrypt || core_start_decrypt) seen_v = 1'b1;
            if (s_ready) seen_r = 1'b1;
        end
        s_valid = 1'b0;
        chk("rr_no_out", 32'(seen_v), 0);
        chk("rr_no_sready", 32'(seen_r), 0);
        do_load(32'h11111111, 1'b0);
        xfer("rr_enc", 32'h00000000, 1'b0, 32'hB4B4B4B4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
